// File: rtl/pepelatz_pkg.sv
// Shared encodings and default widths for the Pepelatz RAM arbiter slice.
package pepelatz_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_AUX  = 1'b1;

endpackage

// File: rtl/pepelatz_rr_pick.sv
// Combinational 2-way round-robin chooser; req[0]=core, req[1]=aux.
module pepelatz_rr_pick
   import pepelatz_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       grant_valid,
   output logic       owner
);

   assign grant_valid = |req;

   always_comb begin
      owner = OWN_CORE;
      if (req == 2'b11)
         owner = ~last_owner;
      else if (req[1])
         owner = OWN_AUX;
   end

endmodule

// File: rtl/pepelatz_ram_arbiter.sv
// Two-master arbiter for the single Pepelatz RAM port, one transaction in flight.
// Optional WAIT timeout enabled by defining PEPELATZ_RAM_TIMEOUT_EN.
module pepelatz_ram_arbiter
   import pepelatz_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_ack,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_adress,
   output logic [DATA_W-1:0] ram_input,
   input  logic [DATA_W-1:0] ram_data,
   input  logic              ram_ready,
   output logic              busy,
   output logic              err
);

   logic [1:0] state;
   logic       last_owner;
   logic       owner;
   logic       grant_valid;
   logic       pick_owner;

   pepelatz_rr_pick u_pick (
      .req         ({aux_req, core_req}),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .owner       (pick_owner)
   );

   assign busy = (state != ST_IDLE);

`ifdef PEPELATZ_RAM_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0] to_cnt;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_owner <= OWN_AUX;
         owner      <= OWN_CORE;
         ram_write  <= 1'b0;
         ram_adress <= '0;
         ram_input  <= '0;
         core_ack   <= 1'b0;
         aux_ack    <= 1'b0;
         core_rdata <= '0;
         aux_rdata  <= '0;
`ifdef PEPELATZ_RAM_TIMEOUT_EN
         err        <= 1'b0;
         to_cnt     <= '0;
`endif
      end else begin
         // acks/err are registered on the WAIT->DONE edge so they cover DONE only
         core_ack <= 1'b0;
         aux_ack  <= 1'b0;
`ifdef PEPELATZ_RAM_TIMEOUT_EN
         err      <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner      <= pick_owner;
                  ram_write  <= (pick_owner == OWN_AUX) ? aux_we    : core_we;
                  ram_adress <= (pick_owner == OWN_AUX) ? aux_addr  : core_addr;
                  ram_input  <= (pick_owner == OWN_AUX) ? aux_wdata : core_wdata;
`ifdef PEPELATZ_RAM_TIMEOUT_EN
                  to_cnt     <= '0;
`endif
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (ram_ready) begin
                  ram_write <= 1'b0;
                  if (owner == OWN_AUX) begin
                     aux_ack   <= 1'b1;
                     aux_rdata <= ram_write ? '0 : ram_data;
                  end else begin
                     core_ack   <= 1'b1;
                     core_rdata <= ram_write ? '0 : ram_data;
                  end
                  state <= ST_DONE;
               end
`ifdef PEPELATZ_RAM_TIMEOUT_EN
               else if (to_cnt == TO_LIM - 8'd1) begin
                  ram_write <= 1'b0;
                  err       <= 1'b1;
                  if (owner == OWN_AUX) begin
                     aux_ack   <= 1'b1;
                     aux_rdata <= '1;
                  end else begin
                     core_ack   <= 1'b1;
                     core_rdata <= '1;
                  end
                  state <= ST_DONE;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
`endif
            end
            ST_DONE: begin
               last_owner <= owner;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pepelatz_ram_arbiter.sv
// Directed-vector bench for pepelatz_ram_arbiter; inputs change 1ns after posedge, outputs sampled there.
module tb_pepelatz_ram_arbiter;

`ifdef PEPELATZ_RAM_TIMEOUT_EN
   localparam int TO_CYC = 8;
`else
   localparam int TO_CYC = 255;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        core_req = 0, core_we = 0, aux_req = 0, aux_we = 0;
   logic [15:0] core_addr = '0, core_wdata = '0, aux_addr = '0, aux_wdata = '0;
   logic        core_ack, aux_ack, ram_write, busy, err;
   logic [15:0] core_rdata, aux_rdata, ram_adress, ram_input;
   logic [15:0] ram_data = '0;
   logic        ram_ready = 1'b0;

   int nvec = 0;
   int nmis = 0;

   pepelatz_ram_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_ack(aux_ack), .aux_rdata(aux_rdata),
      .ram_write(ram_write), .ram_adress(ram_adress), .ram_input(ram_input),
      .ram_data(ram_data), .ram_ready(ram_ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] seq;
      int         nack;
      int         acks_seen;

      #1;
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_wr", ram_write, 0);
      chk("rst_addr", ram_adress, 0);
      chk("rst_in", ram_input, 0);
      chk("rst_acks", {core_ack, aux_ack}, 0);
      chk("rst_rdata", {core_rdata, aux_rdata}, 0);
      chk("rst_err", err, 0);

      // 1: core read, ready k=3, ack at N+5
      core_req = 1; core_we = 0; core_addr = 16'h0040;
      tick();                                   // N+1
      chk("t1_busy", busy, 1);
      chk("t1_addr", ram_adress, 16'h0040);
      chk("t1_wr", ram_write, 0);
      tick(); tick(); tick();                   // N+4
      chk("t1_early_ack", core_ack, 0);
      ram_ready = 1; ram_data = 16'hBEEF;
      tick();                                   // N+5
      ram_ready = 0; ram_data = 16'h0000;
      chk("t1_ack", core_ack, 1);
      chk("t1_rdata", core_rdata, 16'hBEEF);
      chk("t1_aux_ack", aux_ack, 0);
      core_req = 0;
      tick();
      chk("t1_ack_pulse", core_ack, 0);
      chk("t1_idle", busy, 0);

      // 2: aux write, k=0
      aux_req = 1; aux_we = 1; aux_addr = 16'h00FF; aux_wdata = 16'h1234;
      chk("t2_wr_pre", ram_write, 0);
      tick();                                   // N+1
      chk("t2_wr", ram_write, 1);
      chk("t2_addr", ram_adress, 16'h00FF);
      chk("t2_in", ram_input, 16'h1234);
      ram_ready = 1; ram_data = 16'hAAAA;
      tick();                                   // N+2
      ram_ready = 0;
      chk("t2_wr_done", ram_write, 0);
      chk("t2_ack", aux_ack, 1);
      chk("t2_rdata", aux_rdata, 16'h0000);
      chk("t2_core_ack", core_ack, 0);
      aux_req = 0; aux_we = 0;
      tick();
      chk("t2_ack_pulse", aux_ack, 0);
      chk("t2_idle", busy, 0);

      // 6: ram_ready while IDLE is ignored
      ram_ready = 1;
      tick();
      chk("t6_busy", busy, 0);
      chk("t6_acks", {core_ack, aux_ack}, 0);
      tick();
      ram_ready = 0;
      chk("t6_busy2", busy, 0);
      chk("t6_acks2", {core_ack, aux_ack}, 0);

      // 3: both requesting, ram_ready always high -> core, aux, core, aux
      do_reset();
      core_req = 1; core_we = 0; core_addr = 16'h0010;
      aux_req = 1; aux_we = 0; aux_addr = 16'h0020;
      ram_ready = 1; ram_data = 16'h5A5A;
      seq = '0; acks_seen = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (core_ack && aux_ack) chk("t3_both_acks", 1, 0);
         if ((core_ack || aux_ack) && acks_seen < 4) begin
            seq[acks_seen] = aux_ack;
            acks_seen++;
         end
      end
      chk("t3_nacks", acks_seen, 4);
      chk("t3_order", seq, 4'b1010);
      chk("t3_core_rdata", core_rdata, 16'h5A5A);
      chk("t3_aux_rdata", aux_rdata, 16'h5A5A);
      core_req = 0; aux_req = 0; ram_ready = 0;

      // 4: reset during WAIT abandons access
      do_reset();
      core_req = 1; core_we = 0; core_addr = 16'h0080;
      tick();                                   // WAIT
      chk("t4_wait", busy, 1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("t4_busy", busy, 0);
      chk("t4_wr", ram_write, 0);
      chk("t4_addr", ram_adress, 0);
      chk("t4_ack", core_ack, 0);
      tick();                                   // fresh grant with req still held
      chk("t4_regrant", ram_adress, 16'h0080);
      ram_ready = 1; ram_data = 16'h1111;
      tick();
      ram_ready = 0;
      chk("t4_ack2", core_ack, 1);
      chk("t4_rdata", core_rdata, 16'h1111);
      core_req = 0;
      tick();

      // 5: read with ram_ready never asserted
      core_req = 1; core_we = 0; core_addr = 16'h0300;
`ifdef PEPELATZ_RAM_TIMEOUT_EN
      nack = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (core_ack) nack++;
      end
      chk("t5_no_early_ack", nack, 0);
      tick();
      chk("t5_ack", core_ack, 1);
      chk("t5_rdata", core_rdata, 16'hFFFF);
      chk("t5_err", err, 1);
      core_req = 0;
      tick();
      chk("t5_err_pulse", err, 0);
`else
      nack = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (core_ack || aux_ack || err) nack++;
      end
      chk("t5_no_ack", nack, 0);
      chk("t5_busy", busy, 1);
      core_req = 0;
      do_reset();
      chk("t5_recover", busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
